// File: rtl/sp_dma_rd_seq.sv
// sp_dma_rd_seq: read-side address sequencer for the SP DMA path.
// Takes a start address and beat count, then presents one doubleword read
// address per beat on a valid/ready handshake toward the DMEM/IMEM read mux,
// and pulses done the cycle after the final beat is accepted.
//
// Handshake: a beat transfers on a rising clk edge where rd_valid & rd_ready.
// rd_valid and rd_addr are pure register outputs (no path from rd_ready);
// while rd_valid=1 and rd_ready=0 both hold stable, and rd_valid never drops
// before the last beat of the burst has been accepted.
//
// Optional feature macro: SP_DMA_RD_SEQ_STRIDE_EN adds multi-row bursts
// (rows/skip inputs). With it undefined, every burst is a single row.
// dbg_state exposes the FSM state (0 = IDLE, 1 = RUN).
module sp_dma_rd_seq #(
    parameter int AW = 10,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] len,
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    input  logic [7:0]    rows,
    input  logic [AW-1:0] skip,
`endif
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic          dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] w_rem_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_accept;
    logic          w_row_last;
    logic          w_last;

`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    // Per-burst row geometry, captured with start.
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_len_nxt;
    logic [AW-1:0] r_skip;
    logic [AW-1:0] w_skip_nxt;
    logic [7:0]    r_rows_rem;
    logic [7:0]    w_rows_rem_nxt;
`endif

    assign w_accept   = (r_state == S_RUN) && rd_ready;
    assign w_row_last = (r_rem == '0);
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    assign w_last     = w_row_last && (r_rows_rem == 8'd0);
`else
    assign w_last     = w_row_last;
`endif

    // State and datapath registers; async reset drops any burst in flight.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
            r_len      <= '0;
            r_skip     <= '0;
            r_rows_rem <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_done     <= w_done_nxt;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
            r_len      <= w_len_nxt;
            r_skip     <= w_skip_nxt;
            r_rows_rem <= w_rows_rem_nxt;
`endif
        end
    end

    // Next-state and datapath update: capture on start, step on each accept.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_rem_nxt      = r_rem;
        w_done_nxt     = 1'b0;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
        w_len_nxt      = r_len;
        w_skip_nxt     = r_skip;
        w_rows_rem_nxt = r_rows_rem;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_RUN;
                    w_addr_nxt     = start_addr;
                    w_rem_nxt      = len;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
                    w_len_nxt      = len;
                    w_skip_nxt     = skip;
                    w_rows_rem_nxt = rows;
`endif
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (w_last) begin
                        // Address is left on the final beat; only done matters.
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
                    end else if (w_row_last) begin
                        // Jump to the next row with no bubble cycle.
                        w_addr_nxt     = r_addr + AW'(1) + r_skip;
                        w_rem_nxt      = r_len;
                        w_rows_rem_nxt = r_rows_rem - 8'd1;
`endif
                    end else begin
                        w_addr_nxt = r_addr + AW'(1);
                        w_rem_nxt  = r_rem - LW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_addr   = r_addr;
    assign rd_valid  = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign dbg_state = (r_state == S_RUN);

endmodule

// File: tb/tb_sp_dma_rd_seq.sv
// Testbench for sp_dma_rd_seq: randomized bursts against an address-list
// reference model, with a decoupled monitor checking beats, stalls and done.
module tb_sp_dma_rd_seq;
  localparam int AW = 10;
  localparam int LW = 10;
  localparam int W  = AW + 1;   // {last_flag, addr}

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] len = '0;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          dbg_state;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
  logic [7:0]    rows = '0;
  logic [AW-1:0] skip = '0;
`endif

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  int stall_pct = 0;

  // monitor-private state
  logic          pend_done = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_more = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  sp_dma_rd_seq #(.AW(AW), .LW(LW)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    .rows       (rows),
    .skip       (skip),
`endif
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ready driver: random back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rd_ready = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        pend_done = 1'b0;
        prev_stall = 1'b0;
        prev_more = 1'b0;
      end else begin
        if (done || pend_done) check("done_pulse", done, pend_done);
        if (done) check("done_no_valid", rd_valid, 1'b0);
        if (prev_stall) begin
          check("stall_valid", rd_valid, 1'b1);
          check("stall_addr", rd_addr, prev_addr);
        end
        if (prev_more) check("no_bubble", rd_valid, 1'b1);
        pend_done = 1'b0;
        prev_stall = 1'b0;
        prev_more = 1'b0;
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("beat_extra");
          end else begin
            e = exp_q.pop_front();
            check("rd_addr", rd_addr, e[AW-1:0]);
            pend_done = e[AW];
            prev_more = !e[AW];
          end
        end else if (rd_valid) begin
          prev_stall = 1'b1;
          prev_addr = rd_addr;
        end
      end
    end
  end

  task automatic apply_reset();
    reset_l = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset_l = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of done.
  task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [7:0] nr, input logic [AW-1:0] sk,
                           input int noise_pct);
    int cyc;
    logic [AW-1:0] ad;
`ifndef SP_DMA_RD_SEQ_STRIDE_EN
    nr = 8'd0;
    sk = '0;
`endif
    start = 1'b1;
    start_addr = a;
    len = l;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    rows = nr;
    skip = sk;
`endif
    // reference: row r beat b lives at a + r*(len+1+skip) + b, mod 2^AW
    for (int r = 0; r <= int'(nr); r++) begin
      for (int b = 0; b <= int'(l); b++) begin
        ad = AW'(int'(a) + r * (int'(l) + 1 + int'(sk)) + b);
        exp_q.push_back({(r == int'(nr) && b == int'(l)), ad});
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_valid", rd_valid, 1'b1);
    check("first_busy", busy, 1'b1);
    check("first_addr", rd_addr, a);
    check("first_no_done", done, 1'b0);
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 6000) begin
      start = ($urandom_range(0, 99) < noise_pct);
      start_addr = AW'($urandom);
      len = LW'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      fail_now("done_timeout");
      apply_reset();
    end else begin
      check("done_idle_busy", busy, 1'b0);
      check("done_idle_valid", rd_valid, 1'b0);
    end
  endtask

  // stimulus
  initial begin
    reset_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", rd_addr, '0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    #2 reset_l = 1'b1;
    @(negedge clk);
    check("idle_valid", rd_valid, 1'b0);

    // basic burst, full throughput
    stall_pct = 0;
    run_burst(10'h010, 10'd3, 8'd0, '0, 0);
    // same burst with back-pressure
    stall_pct = 50;
    run_burst(10'h010, 10'd3, 8'd0, '0, 0);
    // address wrap, started in the previous done cycle
    stall_pct = 0;
    run_burst(10'h3FE, 10'd3, 8'd0, '0, 0);
    // single beat
    run_burst(10'h123, 10'd0, 8'd0, '0, 0);
    // start held high throughout busy, including the last-accept cycle
    run_burst(10'h055, 10'd5, 8'd0, '0, 100);
    repeat (2) @(negedge clk);
    // maximum length burst
    run_burst(10'h200, 10'h3FF, 8'd0, '0, 0);

    // reset mid-burst: drop everything, no done
    start = 1'b1;
    start_addr = 10'h200;
    len = 10'd7;
`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    rows = 8'd0;
    skip = '0;
`endif
    for (int b = 0; b < 8; b++) exp_q.push_back({(b == 7), AW'(10'h200 + b)});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_l = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", rd_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", rd_addr, '0);
    check("mid_rst_done", done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_done", done, 1'b0);
    end
    #2 reset_l = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 1'b0);
    check("post_rst_state", dbg_state, 1'b0);
    run_burst(10'h0F0, 10'd2, 8'd0, '0, 0);

`ifdef SP_DMA_RD_SEQ_STRIDE_EN
    run_burst(10'h100, 10'd1, 8'd2, 10'd2, 0);
`endif

    // randomized bursts
    for (int i = 0; i < 30; i++) begin
      stall_pct = $urandom_range(0, 60);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_burst(AW'($urandom), LW'($urandom_range(0, 20)), 8'($urandom_range(0, 3)),
                AW'($urandom_range(0, 40)), $urandom_range(0, 30));
    end

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
